// File: rtl/cpu_wb_pkg.sv
// cpu_wb_pkg: writeback-stage constants, default widths and retire entry layout
package cpu_wb_pkg;
  localparam int PC_W        = 32;
  localparam int DBG_WE_W    = 4;
  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int ECODE_W_DEF = 6;
  localparam int DEPTH_DEF   = 2;
  localparam int ECODE_NONE  = 0;
  localparam int ECODE_ADEF  = 'h08;
  localparam int ECODE_SYS   = 'h0b;
  // entry field widths, packed msb-first: pc, gr_we, dest, result, ecode, ertn
  function automatic int entry_w(input int xlen, input int raddr_w, input int ecode_w);
    return PC_W + 1 + raddr_w + xlen + ecode_w + 1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular retire buffer exposing every slot in age order (slot 0 oldest)
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  output logic [DEPTH*W-1:0] slots,
  output logic [DEPTH-1:0]   slot_valid,
  output logic               full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    rptr, wptr;
  logic [AW:0]      cnt;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= push_data;
  // push is applied after pop so a full-buffer push+pop on the same slot keeps it valid
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      vld  <= '0;
    end else begin
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + AW'(1);
      end
      if (push) begin
        vld[wptr] <= 1'b1;
        wptr      <= wptr + AW'(1);
      end
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign full = cnt[AW];
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slots[i*W +: W] = mem[rptr + AW'(i)];
    assign slot_valid[i]   = vld[rptr + AW'(i)];
  end
endmodule

// File: rtl/wb_retire_stage.sv
// wb_retire_stage: in-order retire of buffered instructions into the register file, with exception/ertn flush
module wb_retire_stage
  import cpu_wb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ECODE_W = ECODE_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ms_valid,
  output logic                    ws_allow_in,
  input  logic [PC_W-1:0]         ms_pc,
  input  logic                    ms_gr_we,
  input  logic [RADDR_W-1:0]      ms_dest,
  input  logic [XLEN-1:0]         ms_result,
  input  logic [ECODE_W-1:0]      ms_ecode,
  input  logic                    ms_ertn,
  input  logic                    commit_en,
  output logic                    rf_we,
  output logic [RADDR_W-1:0]      rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [DEPTH-1:0]        fwd_valid,
  output logic [DEPTH*RADDR_W-1:0] fwd_dest,
  output logic [DEPTH*XLEN-1:0]   fwd_data,
  output logic                    wb_ex,
  output logic [PC_W-1:0]         wb_ex_pc,
  output logic [ECODE_W-1:0]      wb_ex_ecode,
  output logic                    wb_ertn,
  output logic [PC_W-1:0]         debug_wb_pc,
  output logic [DBG_WE_W-1:0]     debug_wb_rf_we,
  output logic [RADDR_W-1:0]      debug_wb_rf_wnum,
  output logic [XLEN-1:0]         debug_wb_rf_wdata
);
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic               gr_we;
    logic [RADDR_W-1:0] dest;
    logic [XLEN-1:0]    result;
    logic [ECODE_W-1:0] ecode;
    logic               ertn;
  } entry_t;
  localparam int EW = entry_w(XLEN, RADDR_W, ECODE_W);
  localparam logic [ECODE_W-1:0] NO_EX = ECODE_W'(ECODE_NONE);
  entry_t            head, push_data;
  logic [DEPTH*EW-1:0] slots;
  logic [DEPTH-1:0]  slot_valid;
  logic              full, retire, flush, push;
  assign push_data = {ms_pc, ms_gr_we, ms_dest, ms_result, ms_ecode, ms_ertn};
  assign head      = slots[EW-1:0];
  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_data  (push_data),
    .pop        (retire),
    .slots      (slots),
    .slot_valid (slot_valid),
    .full       (full)
  );
  // retire is masked during reset so a pending head never writes or flushes
  always_comb begin
    retire            = !reset && slot_valid[0] && commit_en;
    wb_ex             = retire && head.ecode != NO_EX;
    wb_ertn           = retire && head.ecode == NO_EX && head.ertn;
    flush             = wb_ex || wb_ertn;
    ws_allow_in       = !flush && (!full || retire);
    push              = ms_valid && ws_allow_in;
    rf_we             = retire && head.gr_we && !wb_ex && !wb_ertn;
    rf_waddr          = rf_we ? head.dest : '0;
    rf_wdata          = rf_we ? head.result : '0;
    wb_ex_pc          = wb_ex ? head.pc : '0;
    wb_ex_ecode       = wb_ex ? head.ecode : '0;
    debug_wb_pc       = retire ? head.pc : '0;
    debug_wb_rf_we    = {DBG_WE_W{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_fwd
    entry_t s;
    assign s                              = slots[i*EW +: EW];
    assign fwd_valid[i]                   = slot_valid[i] && s.gr_we && s.ecode == NO_EX;
    assign fwd_dest[i*RADDR_W +: RADDR_W] = fwd_valid[i] ? s.dest : '0;
    assign fwd_data[i*XLEN +: XLEN]       = fwd_valid[i] ? s.result : '0;
  end
endmodule

// File: tb/tb_wb_retire_stage.sv
// tb_wb_retire_stage: queue-model checking of the retire stage under directed and random traffic
module tb_wb_retire_stage;
  localparam int XLEN = 32, RADDR_W = 5, DEPTH = 2, ECODE_W = 6;
  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [5:0]  ecode;
    logic        ertn;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ms_valid = 1'b0, ms_gr_we = 1'b0, ms_ertn = 1'b0, commit_en = 1'b0;
  logic [31:0] ms_pc = '0, ms_result = '0;
  logic [4:0]  ms_dest = '0;
  logic [5:0]  ms_ecode = '0;
  logic ws_allow_in, rf_we, wb_ex, wb_ertn;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, wb_ex_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_dest;
  logic [63:0] fwd_data;
  logic [5:0]  wb_ex_ecode;
  logic [3:0]  debug_wb_rf_we;
  always #5 clk = ~clk;
  wb_retire_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(DEPTH), .ECODE_W(ECODE_W)) dut (
    .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allow_in(ws_allow_in),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .ms_ecode(ms_ecode), .ms_ertn(ms_ertn), .commit_en(commit_en),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .wb_ex(wb_ex), .wb_ex_pc(wb_ex_pc), .wb_ex_ecode(wb_ex_ecode), .wb_ertn(wb_ertn),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );
  ent_t q[$];
  ent_t cur;
  int n_chk = 0, n_fail = 0;
  logic e_retire, e_ex, e_ertn, e_allow, e_we;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic ent_t mk(input logic [31:0] pc, input logic gr, input logic [4:0] d,
                              input logic [31:0] r, input logic [5:0] ec, input logic er);
    ent_t e;
    e.pc = pc; e.gr_we = gr; e.dest = d; e.res = r; e.ecode = ec; e.ertn = er;
    return e;
  endfunction
  task automatic check_all;
    ent_t h;
    logic [1:0] fv;
    h = (q.size() != 0) ? q[0] : '0;
    e_retire = !reset && q.size() != 0 && commit_en;
    e_ex     = e_retire && h.ecode != 0;
    e_ertn   = e_retire && h.ecode == 0 && h.ertn;
    e_allow  = !(e_ex || e_ertn) && (q.size() < DEPTH || e_retire);
    e_we     = e_retire && h.gr_we && h.ecode == 0 && !h.ertn;
    chk("ws_allow_in", ws_allow_in, e_allow);
    chk("rf_we", rf_we, e_we);
    chk("wb_ex", wb_ex, e_ex);
    chk("wb_ertn", wb_ertn, e_ertn);
    chk("debug_wb_rf_we", debug_wb_rf_we, {4{e_we}});
    if (e_we) begin
      chk("rf_waddr", rf_waddr, h.dest);
      chk("rf_wdata", rf_wdata, h.res);
      chk("debug_wnum", debug_wb_rf_wnum, h.dest);
      chk("debug_wdata", debug_wb_rf_wdata, h.res);
    end
    if (e_retire) chk("debug_wb_pc", debug_wb_pc, h.pc);
    if (e_ex) begin
      chk("wb_ex_pc", wb_ex_pc, h.pc);
      chk("wb_ex_ecode", wb_ex_ecode, h.ecode);
    end
    for (int i = 0; i < DEPTH; i++) begin
      fv[i] = i < q.size() && q[i].gr_we && q[i].ecode == 0;
      if (fv[i]) begin
        chk("fwd_dest", fwd_dest[i*5 +: 5], q[i].dest);
        chk("fwd_data", fwd_data[i*32 +: 32], q[i].res);
      end
    end
    chk("fwd_valid", fwd_valid, fv);
  endtask
  task automatic drive(input logic rst, input logic v, input logic ce, input ent_t e);
    @(negedge clk);
    reset = rst; ms_valid = v; commit_en = ce; cur = e;
    ms_pc = e.pc; ms_gr_we = e.gr_we; ms_dest = e.dest; ms_result = e.res;
    ms_ecode = e.ecode; ms_ertn = e.ertn;
    #1 check_all;
  endtask
  task automatic tick;
    logic push;
    push = ms_valid && e_allow;
    @(posedge clk);
    if (reset || e_ex || e_ertn) q.delete();
    else begin
      if (e_retire) void'(q.pop_front());
      if (push) q.push_back(cur);
    end
  endtask
  task automatic run(input logic rst, input logic v, input logic ce, input ent_t e);
    drive(rst, v, ce, e);
    tick();
  endtask
  initial begin
    ent_t z, e;
    z = '0;
    run(1, 0, 0, z);
    drive(0, 0, 0, z);
    chk("reset allow_in", ws_allow_in, 1);
    chk("reset rf_we", rf_we, 0);
    chk("reset fwd_valid", fwd_valid, 0);
    chk("reset debug_pc", debug_wb_pc, 0);
    tick();
    run(0, 1, 1, mk(32'h1c000000, 1, 3, 32'h12345678, 0, 0));
    drive(0, 0, 1, z);
    chk("first rf_we", rf_we, 1);
    chk("first waddr", rf_waddr, 3);
    chk("first wdata", rf_wdata, 32'h12345678);
    chk("first dbg_we", debug_wb_rf_we, 4'hF);
    tick();
    run(0, 1, 0, mk(32'h1c000004, 1, 4, 32'h44, 0, 0));
    run(0, 1, 0, mk(32'h1c000008, 1, 5, 32'h55, 0, 0));
    drive(0, 1, 0, mk(32'h1c00000c, 1, 6, 32'h66, 0, 0));
    chk("full allow_in", ws_allow_in, 0);
    chk("full fwd_valid", fwd_valid, 2'b11);
    tick();
    drive(0, 0, 1, z);
    chk("order0 waddr", rf_waddr, 4);
    tick();
    drive(0, 0, 1, z);
    chk("order1 waddr", rf_waddr, 5);
    tick();
    drive(0, 0, 1, z);
    chk("third dropped", rf_we, 0);
    tick();
    for (int k = 0; k < 2; k++) run(0, 1, 0, mk(32'h1c000100 + 4 * k, 1, 5'(k + 1), 32'hA0000000 + k, 0, 0));
    for (int k = 2; k < 12; k++) begin
      drive(0, k < 10, 1, mk(32'h1c000100 + 4 * k, 1, 5'(k + 1), 32'hA0000000 + k, 0, 0));
      chk("stream wdata", rf_wdata, 32'hA0000000 + k - 2);
      chk("stream allow", ws_allow_in, 1);
      tick();
    end
    run(0, 1, 0, mk(32'h1c000040, 1, 7, 32'h77, 6'h08, 0));
    run(0, 1, 0, mk(32'h1c000044, 1, 8, 32'h88, 0, 0));
    drive(0, 0, 1, z);
    chk("ex pulse", wb_ex, 1);
    chk("ex pc", wb_ex_pc, 32'h1c000040);
    chk("ex ecode", wb_ex_ecode, 6'h08);
    chk("ex rf_we", rf_we, 0);
    tick();
    drive(0, 0, 1, z);
    chk("ex flushed rf_we", rf_we, 0);
    chk("ex flushed fwd", fwd_valid, 0);
    chk("ex pulse ends", wb_ex, 0);
    tick();
    run(0, 1, 0, mk(32'h1c000080, 0, 0, 0, 0, 1));
    drive(0, 1, 1, mk(32'h1c000084, 1, 9, 32'h99, 0, 0));
    chk("ertn pulse", wb_ertn, 1);
    chk("ertn allow_in", ws_allow_in, 0);
    chk("ertn rf_we", rf_we, 0);
    tick();
    drive(0, 0, 1, z);
    chk("ertn flushed", fwd_valid, 0);
    chk("ertn dropped", rf_we, 0);
    tick();
    run(0, 1, 0, mk(32'h1c0000c0, 1, 10, 32'haa, 0, 0));
    run(0, 1, 0, mk(32'h1c0000c4, 1, 11, 32'hbb, 0, 0));
    drive(1, 0, 1, z);
    chk("rst rf_we", rf_we, 0);
    chk("rst wb_ex", wb_ex, 0);
    tick();
    drive(0, 0, 1, z);
    chk("post-rst allow", ws_allow_in, 1);
    chk("post-rst rf_we", rf_we, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      e = mk($urandom, 1'($urandom), 5'($urandom), $urandom,
             ($urandom_range(7) == 0) ? 6'($urandom_range(63, 1)) : 6'd0,
             $urandom_range(9) == 0);
      run($urandom_range(99) == 0, 1'($urandom), $urandom_range(9) < 7, e);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_retire_stage.md
WB_RETIRE_STAGE -- requirements
Module: wb_retire_stage

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter RADDR_W, default 5, register address width.
REQ-003 Parameter DEPTH, default 2, retire buffer entries; power of two, at least 2.
REQ-004 Parameter ECODE_W, default 6, exception code width; ecode 0 means no exception.
REQ-005 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ms_valid  in  1  memory stage offers an instruction.
REQ-008 ws_allow_in  out  1  buffer can accept an entry this cycle.
REQ-009 ms_pc  in  32; ms_gr_we  in  1; ms_dest  in  RADDR_W; ms_result  in  XLEN; ms_ecode  in  ECODE_W; ms_ertn  in  1: fields of the offered instruction.
REQ-010 commit_en  in  1  head entry may retire this cycle; low holds the head.
REQ-011 rf_we  out  1; rf_waddr  out  RADDR_W; rf_wdata  out  XLEN: register-file write port.
REQ-012 fwd_valid  out  DEPTH; fwd_dest  out  DEPTH*RADDR_W; fwd_data  out  DEPTH*XLEN: pending writes per entry, slot 0 oldest.
REQ-013 wb_ex  out  1; wb_ex_pc  out  32; wb_ex_ecode  out  ECODE_W; wb_ertn  out  1: exception/return flush pulses.
REQ-014 debug_wb_pc  out  32; debug_wb_rf_we  out  4; debug_wb_rf_wnum  out  RADDR_W; debug_wb_rf_wdata  out  XLEN.

Function
REQ-015 ws_allow_in SHALL be high when count<DEPTH, or when count==DEPTH and the head retires this cycle; it SHALL be low in any cycle where wb_ex or wb_ertn is high.
REQ-016 An entry SHALL be written when ms_valid and ws_allow_in are both high; it is capturable for retire at earliest the next cycle (one-cycle latency).
REQ-017 Buffer SHALL be a circular FIFO; read and write pointers SHALL wrap modulo DEPTH; simultaneous push and retire SHALL leave count unchanged.
REQ-018 Head retires when head valid and commit_en high; exactly one entry per cycle.
REQ-019 rf_we SHALL be high only during retire of an entry with gr_we=1, ecode=0, ertn=0; rf_waddr/rf_wdata SHALL then equal the head dest/result.
REQ-020 Writes to register 0 SHALL still drive rf_we; suppression belongs to the register file.
REQ-021 Retire of an entry with ecode!=0 SHALL pulse wb_ex for one cycle with wb_ex_pc/wb_ex_ecode of that entry and no register write.
REQ-022 Retire of an entry with ertn=1 and ecode=0 SHALL pulse wb_ertn for one cycle with no register write.
REQ-023 On the cycle after wb_ex or wb_ertn pulses, all remaining entries SHALL be discarded (count=0); any ms_valid during the pulse cycle SHALL be ignored.
REQ-024 fwd_valid[i] SHALL be high iff slot i (i-th oldest) holds an entry with gr_we=1 and ecode=0; the retiring head SHALL remain visible in its retire cycle.
REQ-025 debug_wb_pc SHALL equal the retiring head pc; debug_wb_rf_we SHALL be {4{rf_we}}; wnum/wdata SHALL mirror rf_waddr/rf_wdata.
REQ-026 When no retire occurs, rf_we, wb_ex, wb_ertn and debug_wb_rf_we SHALL be 0.

Reset
REQ-027 Reset SHALL clear pointers, count and all entry valid bits; ws_allow_in SHALL be 1 and all other outputs 0 in the cycle after reset.
REQ-028 Reset asserted mid-operation SHALL discard buffered entries without any register write or flush pulse.

Structure
REQ-029 Ecode constants, bus widths and the entry field layout SHALL live in shared package cpu_wb_pkg.
REQ-030 Storage and pointers SHALL be one sub-module wb_fifo; exception/flush logic SHALL stay in the top.

Verification
REQ-031 Reset, then push pc=0x1c000000 dest=3 result=0x12345678 gr_we=1, commit_en=1 -> next cycle rf_we=1, waddr=3, wdata=0x12345678, debug_wb_rf_we=0xF.
REQ-032 commit_en=0, push 2 entries -> ws_allow_in=0, fwd_valid=2'b11; third ms_valid ignored; raise commit_en -> two retires on consecutive cycles in order.
REQ-033 Full buffer, commit_en=1, ms_valid=1 every cycle -> one push and one retire per cycle, count stays 2, pointers wrap without loss over 8 entries.
REQ-034 Head ecode=0x08 pc=0x1c000040 with younger entry buffered -> wb_ex=1 one cycle, ex_pc=0x1c000040, ecode=0x08, rf_we=0, younger entry never written, count=0 next cycle.
REQ-035 Head ertn=1 -> wb_ertn one cycle, no write, buffer flushed; ms_valid in same cycle dropped.
REQ-036 Assert reset with 2 entries pending -> no rf_we, wb_ex stays 0, ws_allow_in=1 after release.
